weight_pattern_gen: RTL and testbench

//  Inverse of gen_adder: gen_adder reduces UNIT_SIZE single-bit inputs to their

---
 rtl/weight_pattern_gen.sv | 126 ++++++++++++
 tb/tb_weight_pattern_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_pattern_gen.sv
// Streams every UNIT_SIZE-bit vector with exactly k ones in ascending order,
// one vector per accepted transfer, using Gosper's next-combination step.
module weight_pattern_gen #(
   parameter int UNIT_SIZE = 14,
   parameter int COUNT_W   = 4
) (
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [COUNT_W-1:0]   k,
   input  logic                 abort,
   output logic                 busy,
   output logic                 pat_valid,
   input  logic                 pat_ready,
   output logic [UNIT_SIZE-1:0] pattern,
   output logic                 pat_last,
   output logic                 done,
   output logic                 err
);

   localparam logic [COUNT_W-1:0] U_K = COUNT_W'(UNIT_SIZE);

   typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

   state_t               state_q, state_d;
   logic [COUNT_W-1:0]   k_q, k_d;
   logic [UNIT_SIZE-1:0] pattern_q, pattern_d;
   logic                 err_q, err_d;
   logic [UNIT_SIZE-1:0] start_ones, last_vec, next_vec;
   logic                 is_last;

   function automatic logic [UNIT_SIZE-1:0] low_ones(input logic [COUNT_W-1:0] n);
      logic [UNIT_SIZE-1:0] m;
      if (n >= U_K) m = '1;
      else          m = ~({UNIT_SIZE{1'b1}} << n);
      return m;
   endfunction

   function automatic logic [UNIT_SIZE-1:0] final_pat(input logic [COUNT_W-1:0] n);
      logic [UNIT_SIZE-1:0] m;
      m = low_ones(n);
      if (n <= U_K) m = m << (U_K - n);
      return m;
   endfunction

   // One extra bit keeps the carry out of x + c visible to the shift term.
   function automatic logic [UNIT_SIZE-1:0] gosper(input logic [UNIT_SIZE-1:0] x);
      logic [UNIT_SIZE:0] xe, c, r, t;
      int                 tz;
      xe = {1'b0, x};
      c  = xe & (-xe);
      r  = xe + c;
      tz = 0;
      for (int i = UNIT_SIZE; i >= 0; i--) begin
         if (c[i]) tz = i;
      end
      t = ((r ^ xe) >> 2) >> tz;
      return UNIT_SIZE'(r | t);
   endfunction

   assign start_ones = low_ones(k);
   assign last_vec   = final_pat(k_q);
   assign next_vec   = gosper(pattern_q);
   assign is_last    = (state_q == EMIT) && (pattern_q == last_vec);

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      pattern_d = pattern_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               k_d = k;
               if (k > U_K) begin
                  state_d = FIN;
                  err_d   = 1'b1;
               end else begin
                  state_d   = EMIT;
                  err_d     = 1'b0;
                  pattern_d = start_ones;
               end
            end
         end
         EMIT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (pat_ready) begin
               if (is_last) begin
                  state_d = FIN;
                  err_d   = 1'b0;
               end else begin
                  pattern_d = next_vec;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         pattern_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         pattern_q <= pattern_d;
         err_q     <= err_d;
      end
   end

   assign busy      = (state_q == EMIT);
   assign pat_valid = (state_q == EMIT);
   assign pat_last  = is_last;
   assign pattern   = pattern_q;
   assign done      = (state_q == FIN);
   assign err       = (state_q == FIN) && err_q;

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Randomized scoreboard bench for weight_pattern_gen: expected vectors come from
// enumerating all values with the requested popcount in ascending order.
module tb_weight_pattern_gen;

   localparam int U  = 14;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          pat_ready = 1'b0;
   logic [CW-1:0] k = '0;
   logic          busy, pat_valid, pat_last, done, err;
   logic [U-1:0]  pattern;

   always #5 clock = ~clock;

   weight_pattern_gen #(.UNIT_SIZE(U), .COUNT_W(CW)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .start     (start),
      .k         (k),
      .abort     (abort),
      .busy      (busy),
      .pat_valid (pat_valid),
      .pat_ready (pat_ready),
      .pattern   (pattern),
      .pat_last  (pat_last),
      .done      (done),
      .err       (err)
   );

   int           n_pass = 0;
   int           n_total = 0;
   int           xfer_cnt = 0;
   logic [U-1:0] exp_pat[$];
   bit           exp_last[$];
   bit           exp_done_err[$];
   bit           stall_prev = 1'b0;
   logic [U-1:0] prev_pat = '0;
   logic         prev_last = 1'b0;

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   // Reference: all U-bit values with popcount kk, ascending; last one flagged.
   task automatic build_exp(input int kk);
      exp_pat.delete();
      exp_last.delete();
      for (int v = 0; v < (1 << U); v++) begin
         if ($countones(v) == kk) begin
            exp_pat.push_back(U'(v));
            exp_last.push_back(1'b0);
         end
      end
      if (exp_last.size() > 0) exp_last[exp_last.size()-1] = 1'b1;
   endtask

   // Monitor: samples on the falling edge what the next rising edge will commit.
   always @(negedge clock) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            chk(pat_valid && pattern == prev_pat && pat_last == prev_last, "stall_hold",
                {pat_valid, pat_last, pattern}, {1'b1, prev_last, prev_pat});
         stall_prev = pat_valid && !pat_ready && !abort;
         prev_pat   = pattern;
         prev_last  = pat_last;
         chk(busy == pat_valid, "busy_vs_valid", busy, pat_valid);
         if (pat_valid && pat_ready && !abort) begin
            chk(exp_pat.size() > 0, "xfer_expected", pattern, 0);
            if (exp_pat.size() > 0) begin
               logic [U-1:0] ep;
               bit           el;
               ep = exp_pat.pop_front();
               el = exp_last.pop_front();
               chk(pattern == ep, "pattern", pattern, ep);
               chk(pat_last == el, "pat_last", pat_last, el);
            end
            xfer_cnt++;
         end
         if (done) begin
            chk(exp_done_err.size() > 0, "done_expected", done, 0);
            if (exp_done_err.size() > 0) begin
               bit ee;
               ee = exp_done_err.pop_front();
               chk(err == ee, "err_flag", err, ee);
            end
         end else begin
            chk(!err, "err_without_done", err, 0);
         end
      end
   end

   // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
   task automatic run(input int kk, input int mode, input int abort_after);
      int nexp;
      int cyc;
      int limit;
      bit timed_out;
      build_exp(kk);
      nexp = exp_pat.size();
      xfer_cnt = 0;
      if (kk > U) exp_done_err.push_back(1'b1);
      else if (abort_after < 0) exp_done_err.push_back(1'b0);
      @(posedge clock); #1;
      k = CW'(kk);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      if (kk > U) begin
         chk(done && err && !busy && !pat_valid, "err_run_outputs",
             {done, err, busy, pat_valid}, 4'b1100);
         @(posedge clock); #1;
         chk(!done && !err && !busy && !pat_valid, "err_pulse_one_cycle",
             {done, err, busy, pat_valid}, 4'b0000);
         return;
      end
      chk(busy && pat_valid, "busy_after_start", {busy, pat_valid}, 2'b11);
      cyc = 0;
      limit = 8 * nexp + 50;
      timed_out = 1'b0;
      while (1) begin
         if (abort_after >= 0 && xfer_cnt >= abort_after) begin
            abort = 1'b1;
            @(posedge clock); #1;
            abort = 1'b0;
            pat_ready = 1'b0;
            chk(!busy && !pat_valid && !done, "abort_to_idle",
                {busy, pat_valid, done}, 3'b000);
            chk(xfer_cnt == abort_after, "abort_xfer_count", xfer_cnt, abort_after);
            exp_pat.delete();
            exp_last.delete();
            return;
         end
         case (mode)
            0:       pat_ready = 1'b1;
            1:       pat_ready = (cyc % 3 == 0);
            default: pat_ready = $urandom_range(0, 1) != 0;
         endcase
         @(posedge clock); #1;
         cyc++;
         if (done) break;
         if (cyc > limit) begin
            timed_out = 1'b1;
            break;
         end
      end
      pat_ready = 1'b0;
      chk(!timed_out, "run_timeout", cyc, limit);
      chk(xfer_cnt == nexp, "xfer_count", xfer_cnt, nexp);
      chk(exp_pat.size() == 0, "all_vectors_seen", exp_pat.size(), 0);
      if (mode == 0) chk(cyc == nexp, "zero_bubble_cycles", cyc, nexp);
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk({busy, pat_valid, pat_last, done, err, pattern} == '0, "reset_outputs",
          {busy, pat_valid, pat_last, done, err, pattern}, 0);
      rst_n = 1'b1;

      run(2, 0, -1);
      run(2, 1, -1);
      run(14, 0, -1);
      run(0, 0, -1);

      // start presented while done is high must be ignored
      start = 1'b1;
      k = 4'd3;
      @(posedge clock); #1;
      start = 1'b0;
      chk(!busy && !pat_valid, "start_in_fin_ignored", {busy, pat_valid}, 2'b00);

      run(15, 0, -1);
      run(7, 2, -1);
      run(5, 0, 3);
      run(1, 0, -1);

      // start with abort in IDLE is ignored
      @(posedge clock); #1;
      start = 1'b1;
      abort = 1'b1;
      k = 4'd3;
      @(posedge clock); #1;
      start = 1'b0;
      abort = 1'b0;
      chk(!busy && !pat_valid, "start_abort_ignored", {busy, pat_valid}, 2'b00);
      repeat (3) @(posedge clock);
      #1;
      chk(!busy && !done, "start_abort_stays_idle", {busy, done}, 2'b00);

      // asynchronous reset in the middle of a run
      build_exp(7);
      xfer_cnt = 0;
      k = 4'd7;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      pat_ready = 1'b1;
      repeat (5) @(posedge clock);
      #2;
      rst_n = 1'b0;
      #1;
      chk({busy, pat_valid, pat_last, done, err, pattern} == '0, "midrun_reset_outputs",
          {busy, pat_valid, pat_last, done, err, pattern}, 0);
      chk(xfer_cnt == 5, "midrun_xfers_before_reset", xfer_cnt, 5);
      exp_pat.delete();
      exp_last.delete();
      pat_ready = 1'b0;
      @(posedge clock); #1;
      rst_n = 1'b1;

      run(3, 1, -1);
      repeat (3) run(int'($urandom_range(0, U)), 2, -1);
      run(13, 2, -1);

      @(posedge clock); #1;
      chk(exp_done_err.size() == 0, "no_pending_done", exp_done_err.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
      $fatal(1);
   end

endmodule
